bp_be_mem_port_arb: RTL and testbench
=====================================

BP_BE_MEM_PORT_ARB -- requirements
Module: bp_be_mem_port_arb

Interface
REQ-001 SHALL have parameter pkt_width_p, default 128: width of the memory request packet (reservation image) in bits.
REQ-002 SHALL have parameter max_replay_p, default 3: number of consecutive replays allowed before backoff.
REQ-003 SHALL have port clk_i, input, 1: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_i, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port flush_i, input, 1: kills any speculative (core-sourced) transaction.
REQ-006 SHALL have port core_v_i, input, 1: core (issue-stage) request valid.
REQ-007 SHALL have port core_pkt_i, input, pkt_width_p: core request packet.
REQ-008 SHALL have port core_ready_and_o, output, 1: core request accepted when high together with core_v_i.
REQ-009 SHALL have port ptw_v_i, input, 1: page-table-walker request valid.
REQ-010 SHALL have port ptw_pkt_i, input, pkt_width_p: PTW request packet.
REQ-011 SHALL have port ptw_ready_and_o, output, 1: PTW request accepted when high together with ptw_v_i.
REQ-012 SHALL have port mem_v_o, output, 1: issue to the memory pipe this cycle.
REQ-013 SHALL have port mem_pkt_o, output, pkt_width_p: packet issued to the memory pipe.
REQ-014 SHALL have port mem_src_o, output, 1: source of the held transaction (0 = core, 1 = PTW).
REQ-015 SHALL have port busy_i, input, 1: memory pipe busy (registered busy from the pipe).
REQ-016 SHALL have port result_v_i, input, 1: outcome of the outstanding issue is valid.
REQ-017 SHALL have port replay_i, input, 1: qualifies result_v_i; the issue must be replayed.
REQ-018 SHALL have port miss_i, input, 1: qualifies result_v_i; the issue missed and completes via late writeback.
REQ-019 SHALL have port late_v_i, input, 1: late writeback for the outstanding miss has completed.
REQ-020 SHALL have port ptw_resp_v_o, output, 1: one-cycle pulse when a PTW transaction completes.

Function
REQ-021 SHALL implement an FSM with states IDLE, ISSUE, WAIT, MISS, BACKOFF; the reset state is IDLE.
REQ-022 SHALL drive readies only in IDLE, with ~busy_i and ~reset_i: ptw_ready_and_o = that; core_ready_and_o = that & ~ptw_v_i & ~flush_i (PTW has fixed priority).
REQ-023 SHALL, on a handshake, capture the packet and source into a holding register and go to ISSUE.
REQ-024 SHALL, in ISSUE, assert mem_v_o for exactly one cycle with mem_pkt_o equal to the held packet, then go to WAIT; acceptance-to-mem_v_o latency SHALL be 1 cycle.
REQ-025 SHALL, in WAIT on result_v_i & ~replay_i & ~miss_i, return to IDLE and clear the replay counter; if the source is PTW, it SHALL pulse ptw_resp_v_o in that same cycle.
REQ-026 SHALL, in WAIT on result_v_i & replay_i, increment a saturating replay counter (width clog2(max_replay_p+1)) and go to ISSUE; if the incremented value equals max_replay_p, it SHALL instead go to BACKOFF and clear the counter.
REQ-027 SHALL give replay_i priority when replay_i and miss_i are both high.
REQ-028 SHALL, in WAIT on result_v_i & miss_i & ~replay_i, go to MISS.
REQ-029 SHALL, in MISS on late_v_i, return to IDLE, clear the counter and, if the source is PTW, pulse ptw_resp_v_o.
REQ-030 SHALL, in BACKOFF, wait until busy_i is low for one full cycle, then go to ISSUE (the held packet is reissued).
REQ-031 SHALL, on flush_i with source = core in ISSUE, WAIT, MISS or BACKOFF, go to IDLE next cycle, clear the counter and suppress mem_v_o in that cycle.
REQ-032 SHALL ignore flush_i for PTW transactions.
REQ-033 SHALL ignore result_v_i and late_v_i in IDLE and BACKOFF.
REQ-034 SHALL keep mem_pkt_o and mem_src_o stable from capture until return to IDLE.

Reset
REQ-035 SHALL, while reset_i is high, hold mem_v_o=0, ptw_resp_v_o=0, core_ready_and_o=0, ptw_ready_and_o=0, state=IDLE, replay counter=0 and mem_src_o=0.
REQ-036 SHALL, when reset is asserted mid-transaction, discard the held transaction with no ptw_resp_v_o pulse.

Verification
REQ-037 SHALL cover: core_v_i with pkt=0xA5 in IDLE, busy_i=0 -> handshake at cycle 0; mem_v_o=1 with pkt 0xA5 at cycle 1; result hit -> IDLE, no ptw_resp.
REQ-038 SHALL cover: core_v_i and ptw_v_i both high -> ptw granted, core_ready_and_o=0; PTW hit -> ptw_resp_v_o pulses once; core is granted on the next IDLE cycle.
REQ-039 SHALL cover: three consecutive replays with max_replay_p=3 -> two reissues, then BACKOFF; busy_i held 1 for 5 cycles -> reissue one cycle after busy_i falls.
REQ-040 SHALL cover: PTW miss then late_v_i 10 cycles later -> ptw_resp_v_o pulses in the late_v_i cycle; flush_i asserted during MISS has no effect.
REQ-041 SHALL cover: core transaction in WAIT with flush_i=1 -> IDLE next cycle; a later result_v_i is ignored; counter=0.
REQ-042 SHALL cover: reset_i asserted in MISS -> all outputs 0 the next cycle; late_v_i afterwards produces no pulse.

Source files
------------

// File: rtl/bp_be_mem_port_arb.sv
// bp_be_mem_port_arb: arbitrates core and PTW requests onto the memory pipe with replay, backoff, miss and flush handling
module bp_be_mem_port_arb #(
    parameter int pkt_width_p  = 128,
    parameter int max_replay_p = 3
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   flush_i,
    input  logic                   core_v_i,
    input  logic [pkt_width_p-1:0] core_pkt_i,
    output logic                   core_ready_and_o,
    input  logic                   ptw_v_i,
    input  logic [pkt_width_p-1:0] ptw_pkt_i,
    output logic                   ptw_ready_and_o,
    output logic                   mem_v_o,
    output logic [pkt_width_p-1:0] mem_pkt_o,
    output logic                   mem_src_o,
    input  logic                   busy_i,
    input  logic                   result_v_i,
    input  logic                   replay_i,
    input  logic                   miss_i,
    input  logic                   late_v_i,
    output logic                   ptw_resp_v_o
);
    localparam int cnt_w_lp = $clog2(max_replay_p + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, MISS, BACKOFF} state_e;

    state_e                 state_q, state_d;
    logic [cnt_w_lp-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [pkt_width_p-1:0] pkt_q, pkt_d;
    logic                   src_q, src_d;
    logic                   grant, ptw_hs, core_hs, kill, at_max;

    always_comb begin
        grant            = (state_q == IDLE) & ~busy_i & ~reset_i;
        ptw_ready_and_o  = grant;
        core_ready_and_o = grant & ~ptw_v_i & ~flush_i;
        ptw_hs           = ptw_v_i & ptw_ready_and_o;
        core_hs          = core_v_i & core_ready_and_o;
        kill             = flush_i & ~src_q & (state_q != IDLE);
        cnt_inc          = (cnt_q == cnt_w_lp'(max_replay_p)) ? cnt_q : cnt_q + 1'b1;
        at_max           = cnt_inc == cnt_w_lp'(max_replay_p);
        state_d          = state_q;
        cnt_d            = cnt_q;
        pkt_d            = pkt_q;
        src_d            = src_q;
        mem_v_o          = 1'b0;
        ptw_resp_v_o     = 1'b0;
        unique case (state_q)
            IDLE: if (ptw_hs | core_hs) begin
                state_d = ISSUE;
                pkt_d   = ptw_hs ? ptw_pkt_i : core_pkt_i;
                src_d   = ptw_hs;
            end
            ISSUE: begin
                mem_v_o = ~reset_i;
                state_d = WAIT;
            end
            WAIT: if (result_v_i) begin
                if (replay_i) begin
                    state_d = at_max ? BACKOFF : ISSUE;
                    cnt_d   = at_max ? '0 : cnt_inc;
                end else if (miss_i) begin
                    state_d = MISS;
                end else begin
                    state_d      = IDLE;
                    cnt_d        = '0;
                    ptw_resp_v_o = src_q & ~reset_i;
                end
            end
            MISS: if (late_v_i) begin
                state_d      = IDLE;
                cnt_d        = '0;
                ptw_resp_v_o = src_q & ~reset_i;
            end
            BACKOFF: state_d = busy_i ? BACKOFF : ISSUE;
            default: state_d = IDLE;
        endcase
        if (kill) begin
            state_d = IDLE;
            cnt_d   = '0;
            mem_v_o = 1'b0;
        end
        mem_pkt_o = pkt_q;
        mem_src_o = src_q & ~reset_i;
    end

    always_ff @(posedge clk_i) begin
        pkt_q <= pkt_d;
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            src_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
        end
    end
endmodule

// File: tb/tb_bp_be_mem_port_arb.sv
// tb_bp_be_mem_port_arb: directed and random checks of the memory port arbiter against a transaction-level model
module tb_bp_be_mem_port_arb;
    localparam int W = 128;
    localparam int MAXR = 3;
    localparam int P_IDLE = 0, P_ISSUE = 1, P_WAIT = 2, P_MISS = 3, P_BACK = 4;

    logic clk = 1'b0;
    logic rst, flush, core_v, ptw_v, busy, rv, rp, ms, late;
    logic [W-1:0] core_pkt, ptw_pkt, mem_pkt;
    logic core_rdy, ptw_rdy, mem_v, mem_src, resp;

    int n_chk = 0, n_pass = 0;
    int ph = P_IDLE, m_rep = 0;
    bit m_src = 1'b0;
    logic [W-1:0] m_pkt = '0;

    always #5 clk = ~clk;

    bp_be_mem_port_arb #(.pkt_width_p(W), .max_replay_p(MAXR)) dut (
        .clk_i(clk), .reset_i(rst), .flush_i(flush),
        .core_v_i(core_v), .core_pkt_i(core_pkt), .core_ready_and_o(core_rdy),
        .ptw_v_i(ptw_v), .ptw_pkt_i(ptw_pkt), .ptw_ready_and_o(ptw_rdy),
        .mem_v_o(mem_v), .mem_pkt_o(mem_pkt), .mem_src_o(mem_src),
        .busy_i(busy), .result_v_i(rv), .replay_i(rp), .miss_i(ms),
        .late_v_i(late), .ptw_resp_v_o(resp)
    );

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clear_in();
        {rst, flush, core_v, ptw_v, busy, rv, rp, ms, late} = '0;
    endtask

    // Checks every output against the model for the inputs now applied, then advances one clock.
    task automatic tick(input string t);
        bit idle, e_pr, e_cr, kill, e_mv, e_resp;
        #1;
        idle   = ph == P_IDLE;
        e_pr   = idle && !busy && !rst;
        e_cr   = e_pr && !ptw_v && !flush;
        kill   = !idle && flush && !m_src;
        e_mv   = ph == P_ISSUE && !kill && !rst;
        e_resp = !rst && m_src && ((ph == P_WAIT && rv && !rp && !ms) || (ph == P_MISS && late));
        chk({t, ".ptw_ready"}, W'(ptw_rdy), W'(e_pr));
        chk({t, ".core_ready"}, W'(core_rdy), W'(e_cr));
        chk({t, ".mem_v"}, W'(mem_v), W'(e_mv));
        chk({t, ".ptw_resp"}, W'(resp), W'(e_resp));
        chk({t, ".mem_src"}, W'(mem_src), W'(rst ? 1'b0 : m_src));
        if (!idle && !rst) chk({t, ".mem_pkt"}, mem_pkt, m_pkt);
        @(posedge clk);
        if (rst) begin
            ph = P_IDLE; m_rep = 0; m_src = 1'b0;
        end else if (kill) begin
            ph = P_IDLE; m_rep = 0;
        end else if (idle) begin
            if (e_pr && ptw_v) begin
                ph = P_ISSUE; m_src = 1'b1; m_pkt = ptw_pkt;
            end else if (e_cr && core_v) begin
                ph = P_ISSUE; m_src = 1'b0; m_pkt = core_pkt;
            end
        end else if (ph == P_ISSUE) ph = P_WAIT;
        else if (ph == P_WAIT && rv) begin
            if (rp) begin
                m_rep++;
                if (m_rep == MAXR) begin ph = P_BACK; m_rep = 0; end
                else ph = P_ISSUE;
            end else if (ms) ph = P_MISS;
            else begin ph = P_IDLE; m_rep = 0; end
        end else if (ph == P_MISS && late) begin ph = P_IDLE; m_rep = 0; end
        else if (ph == P_BACK && !busy) ph = P_ISSUE;
        #1;
    endtask

    initial begin
        clear_in();
        core_pkt = '0; ptw_pkt = '0;
        rst = 1'b1; core_v = 1'b1; ptw_v = 1'b1;
        #1;
        chk("rst.core_ready", W'(core_rdy), W'(0));
        chk("rst.ptw_ready", W'(ptw_rdy), W'(0));
        tick("rst0");
        tick("rst1");
        clear_in();
        core_v = 1'b1; core_pkt = W'(8'hA5);
        #1 chk("hit.accept", W'(core_rdy), W'(1));
        tick("hit.c0");
        core_v = 1'b0;
        #1 chk("hit.issue", W'(mem_v), W'(1));
        chk("hit.pkt", mem_pkt, W'(8'hA5));
        tick("hit.c1");
        rv = 1'b1;
        tick("hit.res");
        rv = 1'b0;
        core_v = 1'b1; ptw_v = 1'b1; core_pkt = W'(8'h11); ptw_pkt = W'(8'h22);
        #1 chk("prio.core_ready", W'(core_rdy), W'(0));
        chk("prio.ptw_ready", W'(ptw_rdy), W'(1));
        tick("prio.acc");
        ptw_v = 1'b0;
        tick("prio.issue");
        rv = 1'b1;
        #1 chk("prio.resp", W'(resp), W'(1));
        tick("prio.res");
        rv = 1'b0;
        #1 chk("prio.core_next", W'(core_rdy), W'(1));
        tick("prio.core_acc");
        core_v = 1'b0;
        tick("prio.core_issue");
        rv = 1'b1;
        tick("prio.core_res");
        rv = 1'b0;
        core_v = 1'b1; core_pkt = W'(8'h33);
        tick("rep.acc");
        core_v = 1'b0;
        tick("rep.issue");
        for (int i = 0; i < 3; i++) begin
            rv = 1'b1; rp = 1'b1;
            tick("rep.res");
            rv = 1'b0; rp = 1'b0;
            if (i < 2) begin
                #1 chk("rep.reissue", W'(mem_v), W'(1));
                tick("rep.reissue_t");
            end
        end
        busy = 1'b1;
        for (int i = 0; i < 5; i++) tick("back.busy");
        busy = 1'b0;
        #1 chk("back.quiet", W'(mem_v), W'(0));
        tick("back.fall");
        #1 chk("back.reissue", W'(mem_v), W'(1));
        chk("back.pkt", mem_pkt, W'(8'h33));
        tick("back.issue");
        rv = 1'b1;
        tick("back.res");
        rv = 1'b0;
        ptw_v = 1'b1; ptw_pkt = W'(8'h44);
        tick("miss.acc");
        ptw_v = 1'b0;
        tick("miss.issue");
        rv = 1'b1; ms = 1'b1;
        tick("miss.res");
        rv = 1'b0; ms = 1'b0;
        for (int i = 0; i < 9; i++) begin
            flush = (i % 3 == 1);
            tick("miss.wait");
        end
        flush = 1'b0; late = 1'b1;
        #1 chk("miss.late_resp", W'(resp), W'(1));
        tick("miss.late");
        late = 1'b0;
        core_v = 1'b1; core_pkt = W'(8'h55);
        tick("fl.acc");
        core_v = 1'b0;
        tick("fl.issue");
        rv = 1'b1; rp = 1'b1;
        tick("fl.replay");
        rv = 1'b0; rp = 1'b0;
        tick("fl.reissue");
        flush = 1'b1;
        tick("fl.flush");
        flush = 1'b0; rv = 1'b1;
        #1 chk("fl.idle", W'(ptw_rdy), W'(1));
        tick("fl.stale");
        rv = 1'b0; core_v = 1'b1; core_pkt = W'(8'h66);
        tick("fl.acc2");
        core_v = 1'b0;
        tick("fl.issue2");
        for (int i = 0; i < 2; i++) begin
            rv = 1'b1; rp = 1'b1;
            tick("fl.rep2");
            rv = 1'b0; rp = 1'b0;
            #1 chk("fl.cnt_cleared", W'(mem_v), W'(1));
            tick("fl.reissue2");
        end
        rv = 1'b1;
        tick("fl.done");
        rv = 1'b0;
        ptw_v = 1'b1; ptw_pkt = W'(8'h77);
        tick("rm.acc");
        ptw_v = 1'b0;
        tick("rm.issue");
        rv = 1'b1; ms = 1'b1;
        tick("rm.miss");
        rv = 1'b0; ms = 1'b0; rst = 1'b1;
        tick("rm.reset");
        rst = 1'b0; late = 1'b1;
        #1 chk("rm.no_resp", W'(resp), W'(0));
        chk("rm.src", W'(mem_src), W'(0));
        tick("rm.late");
        late = 1'b0;
        for (int i = 0; i < 600; i++) begin
            rst      = $urandom_range(99) < 2;
            flush    = $urandom_range(99) < 10;
            core_v   = $urandom_range(99) < 50;
            ptw_v    = $urandom_range(99) < 30;
            busy     = $urandom_range(99) < 30;
            rv       = $urandom_range(99) < 40;
            rp       = $urandom_range(99) < 35;
            ms       = $urandom_range(99) < 30;
            late     = $urandom_range(99) < 20;
            core_pkt = {$urandom, $urandom, $urandom, $urandom};
            ptw_pkt  = {$urandom, $urandom, $urandom, $urandom};
            tick("rnd");
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
